// File: rtl/button_conditioner.sv
// Push-button front end: per-channel 2-FF synchronizer, counter debouncer and press/release pulse generator.
// Optional long-press pulse (btn_hold) is built only when LONG_PRESS_EN is defined.
module button_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int HOLD_W          = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_hold
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_r;
  logic [NUM_BTN-1:0] sync2_r;
  logic [NUM_BTN-1:0] level_r;
  logic [NUM_BTN-1:0] press_r;
  logic [NUM_BTN-1:0] release_r;
  logic [CNT_W-1:0]   cnt_r [NUM_BTN];
  logic [NUM_BTN-1:0] mismatch_s;
  logic [NUM_BTN-1:0] accept_s;

  // Two-stage synchronizer for the asynchronous button levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // A level change is accepted on the cycle its stability count completes
  always_comb begin
    mismatch_s = sync2_r ^ level_r;
    accept_s   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      accept_s[i] = mismatch_s[i] && (cnt_r[i] == DEB_LAST);
    end
  end

  // Debounce counters: count consecutive mismatch cycles, restart on any agreement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (accept_s[i]) begin
          cnt_r[i] <= '0;
        end else if (mismatch_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // Debounced level and edge pulses, registered together so a pulse coincides with the new level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r   <= '0;
      press_r   <= '0;
      release_r <= '0;
    end else begin
      level_r   <= level_r ^ accept_s;
      press_r   <= accept_s & ~level_r;
      release_r <= accept_s & level_r;
    end
  end

  assign btn_level   = level_r;
  assign btn_press   = press_r;
  assign btn_release = release_r;

`ifdef LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0]  hold_cnt_r [NUM_BTN];
  logic [NUM_BTN-1:0] hold_r;

  // Hold counters run while the debounced level is high and park at HOLD_CYCLES (one pulse per press)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        hold_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!level_r[i]) begin
          hold_cnt_r[i] <= '0;
          hold_r[i]     <= 1'b0;
        end else if (hold_cnt_r[i] != HOLD_MAX) begin
          hold_cnt_r[i] <= hold_cnt_r[i] + HOLD_W'(1);
          hold_r[i]     <= (hold_cnt_r[i] == HOLD_LAST);
        end else begin
          hold_r[i]     <= 1'b0;
        end
      end
    end
  end

  assign btn_hold = hold_r;
`else
  // Hold parameters are unused here; folding them into a constant keeps the tie-off self-describing
  localparam logic HOLD_CFG_OK = (HOLD_CYCLES > 0) && (HOLD_W > 0);

  assign btn_hold = {NUM_BTN{1'b0}} & {NUM_BTN{HOLD_CFG_OK}};
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10).
// Long-press expectations are compiled in when LONG_PRESS_EN is defined.
module tb_button_conditioner;

  logic       clk;
  logic       reset;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic [2:0] btn_hold;

  int checks;
  int errors;

  button_conditioner #(
    .NUM_BTN        (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .HOLD_CYCLES    (10),
    .HOLD_W         (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_hold   (btn_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " level"},   32'(btn_level),   32'd0);
    check_eq({tag, " press"},   32'(btn_press),   32'd0);
    check_eq({tag, " release"}, 32'(btn_release), 32'd0);
    check_eq({tag, " hold"},    32'(btn_hold),    32'd0);
  endtask

  // Checks n edges after an input change; the accepted change is expected after edge ev
  task automatic track(input string tag, input int n, input int ev,
                       input logic [2:0] lvl_before, input logic [2:0] lvl_after,
                       input logic [2:0] press_at, input logic [2:0] release_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check_eq($sformatf("%s level e%0d", tag, k), 32'(btn_level), 32'(k >= ev ? lvl_after : lvl_before));
      check_eq($sformatf("%s press e%0d", tag, k), 32'(btn_press), 32'(k == ev ? press_at : 3'b000));
      check_eq($sformatf("%s release e%0d", tag, k), 32'(btn_release), 32'(k == ev ? release_at : 3'b000));
      check_eq($sformatf("%s hold e%0d", tag, k), 32'(btn_hold), 32'd0);
    end
  endtask

  task automatic do_reset(input logic [2:0] raw, input int idle);
    reset   = 1'b0;
    btn_raw = raw;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:15] bounce;
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    btn_raw = 3'b111;

    // 1: buttons held through reset, then accepted 6 edges after release
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_idle("s1 in reset");
    end
    reset = 1'b1;
    track("s1", 8, 6, 3'b000, 3'b111, 3'b111, 3'b000);

    // 2: single channel press
    do_reset(3'b000, 3);
    btn_raw[0] = 1'b1;
    track("s2", 8, 6, 3'b000, 3'b001, 3'b001, 3'b000);

    // 3: bounce shorter than the debounce window is ignored
    do_reset(3'b000, 3);
    bounce = 16'b1110_0110_0000_0000;
    for (int k = 0; k < 16; k++) begin
      btn_raw[1] = bounce[k];
      @(negedge clk);
      check_idle($sformatf("s3 c%0d", k));
    end

    // 4: press then release yields one release pulse and no repeated press
    do_reset(3'b000, 3);
    btn_raw[2] = 1'b1;
    track("s4 press", 8, 6, 3'b000, 3'b100, 3'b100, 3'b000);
    btn_raw[2] = 1'b0;
    track("s4 release", 8, 6, 3'b100, 3'b000, 3'b000, 3'b100);

    // 5: long press
    do_reset(3'b000, 3);
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check_eq($sformatf("s5 press e%0d", k), 32'(btn_press), 32'(k == 6 ? 3'b001 : 3'b000));
`ifdef LONG_PRESS_EN
      check_eq($sformatf("s5 hold e%0d", k), 32'(btn_hold), 32'(k == 16 ? 3'b001 : 3'b000));
`else
      check_eq($sformatf("s5 hold e%0d", k), 32'(btn_hold), 32'd0);
`endif
    end
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("s5 rel hold e%0d", k), 32'(btn_hold), 32'd0);
    end
    check_eq("s5 level back", 32'(btn_level), 32'd0);
    // short press: accepted level stays high for only 8 cycles, below HOLD_CYCLES
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 9) btn_raw[0] = 1'b0;
      @(negedge clk);
      check_eq($sformatf("s5 short hold e%0d", k), 32'(btn_hold), 32'd0);
    end

    // 6: reset mid-count while level is high
    do_reset(3'b000, 3);
    btn_raw[0] = 1'b1;
    track("s6 press", 8, 6, 3'b000, 3'b001, 3'b001, 3'b000);
    btn_raw[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("s6 level before reset", 32'(btn_level), 32'd1);
    reset      = 1'b0;
    btn_raw[0] = 1'b1;
    #1;
    check_idle("s6 async");
    @(negedge clk);
    check_idle("s6 in reset");
    reset = 1'b1;
    track("s6 reaccept", 8, 6, 3'b000, 3'b001, 3'b001, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
